// File: rtl/pc_sequencer.sv
// Program counter sequencer: IDLE/RUN/HALT control with a zero-latency branch
// target table and saturating retired/taken-branch counters.
module pc_sequencer #(
    parameter int unsigned D  = 10,
    parameter int unsigned CW = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          stall,
    input  logic          branch_en,
    input  logic          branch_taken,
    input  logic [3:0]    lut_idx,
    input  logic [D-1:0]  lut_target,
    output logic [3:0]    lut_addr,
    input  logic          halt_req,
    output logic [D-1:0]  pc,
    output logic          fetch_valid,
    output logic          done,
    output logic [CW-1:0] retired,
    output logic [CW-1:0] taken_cnt
);

    typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

    state_t        state;
    logic [CW-1:0] retired_inc;
    logic [CW-1:0] taken_inc;

    assign lut_addr    = lut_idx;
    assign fetch_valid = (state == RUN) && !stall;
    assign done        = (state == HALT);

    // Counters stick at all-ones rather than wrapping.
    assign retired_inc = (retired   == '1) ? retired   : retired   + CW'(1);
    assign taken_inc   = (taken_cnt == '1) ? taken_cnt : taken_cnt + CW'(1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            pc        <= '0;
            retired   <= '0;
            taken_cnt <= '0;
        end else begin
            case (state)
                IDLE, HALT: begin
                    if (start) begin
                        state     <= RUN;
                        pc        <= '0;
                        retired   <= '0;
                        taken_cnt <= '0;
                    end
                end
                RUN: begin
                    if (!stall) begin
                        retired <= retired_inc;
                        if (halt_req) begin
                            state <= HALT;
                        end else if (branch_en && branch_taken) begin
                            pc        <= lut_target;
                            taken_cnt <= taken_inc;
                        end else begin
                            pc <= pc + D'(1);
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer (D=10, CW=4 so saturation is reachable).
module tb_pc_sequencer;

    localparam int unsigned D  = 10;
    localparam int unsigned CW = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic          stall = 1'b0;
    logic          branch_en = 1'b0;
    logic          branch_taken = 1'b0;
    logic [3:0]    lut_idx = '0;
    logic [D-1:0]  lut_target = '0;
    logic [3:0]    lut_addr;
    logic          halt_req = 1'b0;
    logic [D-1:0]  pc;
    logic          fetch_valid;
    logic          done;
    logic [CW-1:0] retired;
    logic [CW-1:0] taken_cnt;

    pc_sequencer #(.D(D), .CW(CW)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .stall       (stall),
        .branch_en   (branch_en),
        .branch_taken(branch_taken),
        .lut_idx     (lut_idx),
        .lut_target  (lut_target),
        .lut_addr    (lut_addr),
        .halt_req    (halt_req),
        .pc          (pc),
        .fetch_valid (fetch_valid),
        .done        (done),
        .retired     (retired),
        .taken_cnt   (taken_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [D-1:0]  pc;
        logic [CW-1:0] ret;
        logic [CW-1:0] tk;
        logic          dn;
    } exp_t;

    exp_t q[$];

    int checks = 0;
    int errors = 0;

    // Reference model state: 0=IDLE 1=RUN 2=HALT
    int            m_state = 0;
    logic [D-1:0]  m_pc = '0;
    logic [CW-1:0] m_ret = '0;
    logic [CW-1:0] m_tk = '0;
    localparam logic [CW-1:0] CMAX = (1 << CW) - 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_state = 0;
        m_pc    = '0;
        m_ret   = '0;
        m_tk    = '0;
    endtask

    // Drive one cycle of inputs, check the combinational outputs, predict the
    // next registered state and compare it after the edge.
    task automatic step(input logic st, input logic stl, input logic ben, input logic btk,
                        input logic [3:0] idx, input logic [D-1:0] tgt, input logic hlt);
        exp_t e;
        exp_t got;
        start = st; stall = stl; branch_en = ben; branch_taken = btk;
        lut_idx = idx; lut_target = tgt; halt_req = hlt;
        #1;
        check_eq("lut_addr", 32'(lut_addr), 32'(idx));
        check_eq("fetch_valid", 32'(fetch_valid), 32'((m_state == 1) && !stl));
        check_eq("done_pre", 32'(done), 32'(m_state == 2));
        case (m_state)
            0, 2: if (st) begin
                m_state = 1; m_pc = '0; m_ret = '0; m_tk = '0;
            end
            default: if (!stl) begin
                m_ret = (m_ret == CMAX) ? m_ret : m_ret + 1'b1;
                if (hlt) m_state = 2;
                else if (ben && btk) begin
                    m_pc = tgt;
                    m_tk = (m_tk == CMAX) ? m_tk : m_tk + 1'b1;
                end else m_pc = m_pc + 1'b1;
            end
        endcase
        e.pc = m_pc; e.ret = m_ret; e.tk = m_tk; e.dn = (m_state == 2);
        q.push_back(e);
        @(posedge clk);
        #1;
        got = q.pop_front();
        check_eq("pc", 32'(pc), 32'(got.pc));
        check_eq("retired", 32'(retired), 32'(got.ret));
        check_eq("taken_cnt", 32'(taken_cnt), 32'(got.tk));
        check_eq("done", 32'(done), 32'(got.dn));
        start = 1'b0;
    endtask

    task automatic seq(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) step(0, 0, 0, 0, 4'd0, '0, 0);
    endtask

    initial begin
        #1 reset = 1'b1;
        #1;
        check_eq("rst_pc", 32'(pc), 0);
        check_eq("rst_fetch_valid", 32'(fetch_valid), 0);
        check_eq("rst_done", 32'(done), 0);
        check_eq("rst_retired", 32'(retired), 0);
        @(posedge clk);
        #1 reset = 1'b0;
        model_reset();

        // Start coincident with first edge after release, then 5 sequential
        step(1, 0, 0, 0, 4'd0, '0, 0);
        check_eq("start_pc", 32'(pc), 0);
        seq(5);
        check_eq("seq5_pc", 32'(pc), 5);
        check_eq("seq5_retired", 32'(retired), 5);

        step(0, 0, 1, 1, 4'd1, 10'd3, 0);
        check_eq("br3_pc", 32'(pc), 3);
        step(0, 0, 1, 1, 4'd2, 10'd80, 0);
        check_eq("br80_pc", 32'(pc), 80);
        check_eq("br80_taken", 32'(taken_cnt), 2);
        step(0, 0, 1, 1, 4'd1, 10'd3, 0);
        step(0, 0, 1, 0, 4'd2, 10'd80, 0);
        check_eq("nt_pc", 32'(pc), 4);
        check_eq("nt_taken", 32'(taken_cnt), 3);
        step(0, 0, 1, 1, 4'd5, 10'd4, 0);
        check_eq("self_pc", 32'(pc), 4);
        seq(3);
        check_eq("pc7", 32'(pc), 7);

        // Stall with halt and branch asserted, then halt on release
        for (int i = 0; i < 3; i++) step(1, 1, 1, 1, 4'd9, 10'd500, 1);
        check_eq("stall_pc", 32'(pc), 7);
        check_eq("stall_retired", 32'(retired), 13);
        step(0, 0, 1, 1, 4'd9, 10'd500, 1);
        check_eq("halt_done", 32'(done), 1);
        check_eq("halt_pc", 32'(pc), 7);
        check_eq("halt_retired", 32'(retired), 14);
        step(0, 1, 1, 1, 4'd3, 10'd9, 0);
        step(0, 0, 0, 0, 4'd0, '0, 0);
        check_eq("halt_hold_pc", 32'(pc), 7);

        // Restart from HALT, ignore start in RUN
        step(1, 0, 0, 0, 4'd0, '0, 0);
        check_eq("restart_pc", 32'(pc), 0);
        check_eq("restart_done", 32'(done), 0);
        check_eq("restart_retired", 32'(retired), 0);
        check_eq("restart_taken", 32'(taken_cnt), 0);
        step(1, 0, 0, 0, 4'd0, '0, 0);
        check_eq("run_start_pc", 32'(pc), 1);

        // PC wrap at all-ones
        step(0, 0, 1, 1, 4'd15, 10'd1023, 0);
        check_eq("pc_max", 32'(pc), 1023);
        seq(1);
        check_eq("pc_wrap", 32'(pc), 0);

        // Counter saturation
        seq(20);
        check_eq("retired_sat", 32'(retired), 15);
        for (int i = 0; i < 16; i++) step(0, 0, 1, 1, 4'd7, 10'd44, 0);
        check_eq("taken_sat", 32'(taken_cnt), 15);
        check_eq("pc44", 32'(pc), 44);

        // Asynchronous reset between edges
        reset = 1'b1;
        #2;
        check_eq("async_pc", 32'(pc), 0);
        check_eq("async_fetch_valid", 32'(fetch_valid), 0);
        check_eq("async_retired", 32'(retired), 0);
        reset = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        seq(3);
        check_eq("idle_pc", 32'(pc), 0);
        check_eq("idle_fetch_valid", 32'(fetch_valid), 0);
        step(1, 0, 0, 0, 4'd0, '0, 0);
        seq(2);
        check_eq("post_reset_pc", 32'(pc), 2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter D, default 10, program counter and branch target width in bits.
REQ-002 Parameter CW, default 16, width of the retired-instruction and taken-branch counters.
REQ-003 Port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 Port reset  input  1  asynchronous, active-high reset.
REQ-005 Port start  input  1  one-cycle pulse that begins program execution from PC 0.
REQ-006 Port stall  input  1  freezes PC, state and counters for the cycle.
REQ-007 Port branch_en  input  1  current instruction is a branch.
REQ-008 Port branch_taken  input  1  branch condition true; meaningful only with branch_en.
REQ-009 Port lut_idx  input  4  branch target table index carried by the instruction.
REQ-010 Port lut_target  input  D  absolute target returned by the branch target table.
REQ-011 Port lut_addr  output  4  index driven to the branch target table.
REQ-012 Port halt_req  input  1  current instruction is the program-end instruction.
REQ-013 Port pc  output  D  current fetch address.
REQ-014 Port fetch_valid  output  1  pc holds a fetch address that is live this cycle.
REQ-015 Port done  output  1  program has halted.
REQ-016 Port retired  output  CW  count of instructions completed since the last start.
REQ-017 Port taken_cnt  output  CW  count of taken branches since the last start.

Function
REQ-018 Three states: IDLE, RUN, HALT; state, pc and counters are registers.
REQ-019 lut_addr SHALL equal lut_idx combinationally in every state; lut_target is consumed in the same cycle (zero-latency table).
REQ-020 fetch_valid SHALL be 1 iff state==RUN and stall==0; done SHALL be 1 iff state==HALT.
REQ-021 IDLE: start=1 -> RUN next cycle, pc=0, retired=0, taken_cnt=0; otherwise hold.
REQ-022 RUN with stall=1: pc, state, retired, taken_cnt hold; all other inputs ignored.
REQ-023 RUN with stall=0, priority halt_req > taken branch > sequential.
REQ-024 halt_req=1 -> HALT, pc holds, retired+1.
REQ-025 branch_en=1 and branch_taken=1 -> pc=lut_target, retired+1, taken_cnt+1.
REQ-026 branch_en=1 and branch_taken=0, or branch_en=0 -> pc=pc+1 modulo 2^D (all-ones wraps to 0), retired+1.
REQ-027 start in RUN SHALL be ignored.
REQ-028 HALT: pc and counters hold; start=1 -> RUN with pc=0 and both counters cleared; stall has no effect in HALT.
REQ-029 retired and taken_cnt SHALL saturate at 2^CW-1, never wrap.
REQ-030 A branch to the current pc (lut_target==pc) SHALL be legal and repeat that address.

Reset
REQ-031 reset=1 SHALL immediately, without a clock edge, force state=IDLE, pc=0, retired=0, taken_cnt=0, so fetch_valid=0 and done=0.
REQ-032 Reset asserted mid-RUN or in HALT SHALL abandon execution; after release the block waits in IDLE for start.
REQ-033 A start coincident with the first edge after reset release SHALL be honoured.

Verification
REQ-034 Reset, start, 5 cycles no branch/stall -> pc 0,1,2,3,4,5; fetch_valid=1; retired=5.
REQ-035 At pc=3, branch_en=1, branch_taken=1, lut_idx=2, lut_target=80 -> lut_addr=2, next pc=80, taken_cnt=1; same with branch_taken=0 -> next pc=4, taken_cnt unchanged.
REQ-036 At pc=7, stall for 3 cycles with halt_req=1 and branch asserted -> pc stays 7, fetch_valid=0, counters unchanged; on release with halt_req=1 -> done=1, pc=7, retired+1.
REQ-037 In HALT pulse start -> next cycle RUN, pc=0, done=0, retired=0, taken_cnt=0; start pulsed again in RUN -> no effect.
REQ-038 Force pc=1023 (D=10) by taken branch with lut_target=1023, then sequential step -> pc=0; with CW=4, 20 instructions -> retired=15.
REQ-039 Assert reset asynchronously between edges mid-RUN at pc=44 -> pc=0, fetch_valid=0 before the next edge; remains IDLE until start.
